// File: rtl/memory_regfile_lanes.sv
// DEPTH x WIDTH register memory with per-lane write enables and a registered read port.
// A hardware sweep zeroes every entry after reset or on a clear request.
module memory_regfile_lanes #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int LANE  = 2,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int NLANES = WIDTH / LANE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              write,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [NLANES-1:0] laneEn,
   input  logic [WIDTH-1:0]  dataIn,
   input  logic              read,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic [WIDTH-1:0]  dataOut,
   output logic              dataValid,
   output logic              busy
);

   typedef enum logic {
      ST_INIT,
      ST_IDLE
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       ptr_q, ptr_d;
   logic [WIDTH-1:0]        mem_q [DEPTH];
   logic [WIDTH-1:0]        dataOut_q, dataOut_d;
   logic                    dataValid_q, dataValid_d;

   logic                    sweep_we;
   logic                    access_ok;
   logic                    wr_in_range, rd_in_range;
   logic                    wr_ok, rd_ok;
   logic [WIDTH-1:0]        wr_word;

   function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0]  old_w,
                                                   input logic [WIDTH-1:0]  new_w,
                                                   input logic [NLANES-1:0] en);
      logic [WIDTH-1:0] res;
      res = old_w;
      for (int i = 0; i < NLANES; i++) begin
         if (en[i]) res[i*LANE +: LANE] = new_w[i*LANE +: LANE];
      end
      return res;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_INIT: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_PTR) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end
         end
         default: ;
      endcase
      if (clear) begin
         state_d = ST_INIT;
         ptr_d   = '0;
      end
   end

   always_comb begin
      busy      = (state_q == ST_INIT);
      sweep_we  = (state_q == ST_INIT);
      access_ok = (state_q == ST_IDLE) && !clear;
   end

   always_comb begin
      wr_in_range = ({1'b0, wrAddr} < DEPTH_EXT);
      rd_in_range = ({1'b0, rdAddr} < DEPTH_EXT);
      wr_ok       = write && access_ok && wr_in_range;
      rd_ok       = read && access_ok;
      wr_word     = lane_merge(mem_q[wrAddr], dataIn, laneEn);

      dataOut_d   = dataOut_q;
      dataValid_d = rd_ok;
      if (rd_ok) begin
         if (!rd_in_range)
            dataOut_d = '0;
         else if (wr_ok && (wrAddr == rdAddr))
            dataOut_d = wr_word;  // write-first bypass
         else
            dataOut_d = mem_q[rdAddr];
      end
   end

   // NOTE: storage is deliberately not reset; the init sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (sweep_we)
         mem_q[ptr_q] <= '0;
      else if (wr_ok)
         mem_q[wrAddr] <= wr_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dataOut_q   <= '0;
         dataValid_q <= 1'b0;
      end else begin
         dataOut_q   <= dataOut_d;
         dataValid_q <= dataValid_d;
      end
   end

   assign dataOut   = dataOut_q;
   assign dataValid = dataValid_q;

endmodule

// File: tb/tb_memory_regfile_lanes.sv
// Directed bench: a DEPTH=4 and a DEPTH=3 instance share one stimulus stream;
// each step checks the instance that matters for it.
module tb_memory_regfile_lanes;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        write;
   logic [1:0]  wrAddr;
   logic [7:0]  laneEn;
   logic [15:0] dataIn;
   logic        read;
   logic [1:0]  rdAddr;

   logic [15:0] d4_out, d3_out;
   logic        d4_valid, d3_valid;
   logic        d4_busy, d3_busy;

   int n_cmp;
   int n_err;

   memory_regfile_lanes #(.WIDTH(16), .DEPTH(4), .LANE(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .write(write), .wrAddr(wrAddr),
      .laneEn(laneEn), .dataIn(dataIn), .read(read), .rdAddr(rdAddr),
      .dataOut(d4_out), .dataValid(d4_valid), .busy(d4_busy)
   );

   memory_regfile_lanes #(.WIDTH(16), .DEPTH(3), .LANE(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .write(write), .wrAddr(wrAddr),
      .laneEn(laneEn), .dataIn(dataIn), .read(read), .rdAddr(rdAddr),
      .dataOut(d3_out), .dataValid(d3_valid), .busy(d3_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [7:0] en);
      write  = 1'b1;
      wrAddr = a;
      dataIn = d;
      laneEn = en;
      step();
      write  = 1'b0;
   endtask

   task automatic rd_chk(input bit use3, input string tag, input logic [1:0] a,
                         input logic [15:0] exp);
      read   = 1'b1;
      rdAddr = a;
      step();
      read   = 1'b0;
      chk({tag, "_data"}, use3 ? d3_out : d4_out, exp);
      chk({tag, "_valid"}, {15'd0, use3 ? d3_valid : d4_valid}, 16'd1);
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      rst_n  = 1'b0;
      clear  = 1'b0;
      write  = 1'b0;
      read   = 1'b0;
      wrAddr = '0;
      rdAddr = '0;
      laneEn = '0;
      dataIn = '0;

      // Reset state
      #12;
      chk("rst_out",   d4_out, 16'h0000);
      chk("rst_valid", {15'd0, d4_valid}, 16'd0);
      chk("rst_busy",  {15'd0, d4_busy}, 16'd1);

      // Release: busy for exactly 4 cycles
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("sweep_busy0", {15'd0, d4_busy}, 16'd1);
      step(); chk("sweep_busy1", {15'd0, d4_busy}, 16'd1);
      step(); chk("sweep_busy2", {15'd0, d4_busy}, 16'd1);
      step(); chk("sweep_busy3", {15'd0, d4_busy}, 16'd1);
      step(); chk("sweep_done",  {15'd0, d4_busy}, 16'd0);

      for (int i = 0; i < 4; i++) rd_chk(1'b0, "init_rd", 2'(i), 16'h0000);
      step();
      chk("valid_drop", {15'd0, d4_valid}, 16'd0);

      // Basic writes and reads
      wr(2'd1, 16'hA5C3, 8'hFF);
      wr(2'd0, 16'h1234, 8'hFF);
      rd_chk(1'b0, "rd1", 2'd1, 16'hA5C3);
      rd_chk(1'b0, "rd0", 2'd0, 16'h1234);

      // Lane-masked write: lanes 0 and 2 zeroed
      wr(2'd2, 16'hFFFF, 8'hFF);
      wr(2'd2, 16'h0000, 8'b0000_0101);
      rd_chk(1'b0, "lane_rd2", 2'd2, 16'hFFCC);

      // Read-during-write same address, write-first
      wr(2'd3, 16'h00FF, 8'hFF);
      read   = 1'b1;
      rdAddr = 2'd3;
      wr(2'd3, 16'hAB00, 8'b1111_0000);
      read   = 1'b0;
      chk("rdw_data",  d4_out, 16'hABFF);
      chk("rdw_valid", {15'd0, d4_valid}, 16'd1);
      step();
      chk("hold_data",  d4_out, 16'hABFF);
      chk("hold_valid", {15'd0, d4_valid}, 16'd0);
      rd_chk(1'b0, "rdw_mem", 2'd3, 16'hABFF);

      // Read and write to different addresses in one cycle
      read   = 1'b1;
      rdAddr = 2'd1;
      wr(2'd0, 16'h7777, 8'hFF);
      read   = 1'b0;
      chk("split_rd", d4_out, 16'hA5C3);
      rd_chk(1'b0, "split_wr", 2'd0, 16'h7777);

      // Populate, then clear with a simultaneous write and read
      wr(2'd0, 16'h1111, 8'hFF);
      wr(2'd1, 16'h2222, 8'hFF);
      wr(2'd2, 16'h3333, 8'hFF);
      wr(2'd3, 16'h4444, 8'hFF);
      clear  = 1'b1;
      read   = 1'b1;
      rdAddr = 2'd1;
      wr(2'd0, 16'h9999, 8'hFF);
      clear  = 1'b0;
      chk("clr_busy0",  {15'd0, d4_busy}, 16'd1);
      chk("clr_valid",  {15'd0, d4_valid}, 16'd0);
      step();                                   // read held high while busy
      read   = 1'b0;
      chk("busy_rd_drop", {15'd0, d4_valid}, 16'd0);
      chk("clr_busy1",  {15'd0, d4_busy}, 16'd1);
      step();
      chk("clr_busy2",  {15'd0, d4_busy}, 16'd1);
      // Restart the sweep at sweep cycle 2
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("rst_sweep0", {15'd0, d4_busy}, 16'd1);
      step(); chk("rst_sweep1", {15'd0, d4_busy}, 16'd1);
      step(); chk("rst_sweep2", {15'd0, d4_busy}, 16'd1);
      step(); chk("rst_sweep3", {15'd0, d4_busy}, 16'd1);
      step(); chk("rst_sweep_done", {15'd0, d4_busy}, 16'd0);
      for (int i = 0; i < 4; i++) rd_chk(1'b0, "clr_rd", 2'(i), 16'h0000);

      // DEPTH=3: out-of-range write ignored, out-of-range read returns 0
      chk("d3_idle", {15'd0, d3_busy}, 16'd0);
      wr(2'd3, 16'h5555, 8'hFF);
      for (int i = 0; i < 3; i++) rd_chk(1'b1, "d3_oor_wr", 2'(i), 16'h0000);
      wr(2'd2, 16'h00AA, 8'hFF);
      rd_chk(1'b1, "d3_rd2", 2'd2, 16'h00AA);
      rd_chk(1'b1, "d3_oor_rd", 2'd3, 16'h0000);

      // Reset mid-traffic: outputs clear immediately
      rd_chk(1'b1, "d3_pre_rst", 2'd2, 16'h00AA);
      write  = 1'b1;
      wrAddr = 2'd0;
      dataIn = 16'hFFFF;
      laneEn = 8'hFF;
      read   = 1'b1;
      rdAddr = 2'd2;
      #2 rst_n = 1'b0;
      #1;
      chk("async_out",   d3_out, 16'h0000);
      chk("async_valid", {15'd0, d3_valid}, 16'd0);
      chk("async_busy",  {15'd0, d3_busy}, 16'd1);
      write = 1'b0;
      read  = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("d3_sweep0", {15'd0, d3_busy}, 16'd1);
      step(); chk("d3_sweep1", {15'd0, d3_busy}, 16'd1);
      step(); chk("d3_sweep2", {15'd0, d3_busy}, 16'd1);
      step(); chk("d3_sweep_done", {15'd0, d3_busy}, 16'd0);
      rd_chk(1'b1, "d3_post_rst", 2'd2, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
